// File: rtl/prio_encode_key.sv
// Sequential priority encoder for raw key/request vectors: debounces the encoded
// index, emits one valid/ready event per press, and re-arms only after a full release.
module prio_encode_key #(
  parameter int N             = 8,
  parameter int W             = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] x,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         out_valid,
  output logic         any
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OUT     = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [N-1:0]  x_q;
  logic [W-1:0]  enc;
  logic          nz;
  logic [W:0]    snapshot;  // {nz, enc} of the pattern currently being timed
  logic [CW-1:0] cnt;
  logic          stable;
  logic [1:0]    state;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    enc = '0;
    for (int i = 0; i < N; i++) begin
      if (x_q[i]) enc = W'(i);
    end
  end

  assign nz     = |x_q;
  assign stable = (cnt == CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      any <= 1'b0;
    end else begin
      x_q <= x;
      any <= |x;
    end
  end

  // Only {nz, enc} is timed, so lower-priority bits can chatter freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snapshot <= '0;
      cnt      <= '0;
    end else if ({nz, enc} == snapshot) begin
      if (!stable) cnt <= cnt + 1'b1;
    end else begin
      snapshot <= {nz, enc};
      cnt      <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && stable && snapshot[W]) begin
            y         <= snapshot[W-1:0];
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        // A presented event is held until consumed, independent of en.
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          if (stable && !snapshot[W]) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
